// File: rtl/blur_border_masker.sv
// Border masker for the blur filter output: tracks pixel position from SOP, blanks pixels whose
// kernel is incomplete, repairs SOP/EOP framing and registers the output beat.
// Optional BORDER_STATS_EN adds frame_count / err_count statistics outputs.
module blur_border_masker #(
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned DATA_W = 12,
  parameter logic [DATA_W-1:0] BORDER_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        freq_flag,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [DATA_W-1:0] data_out,
`ifdef BORDER_STATS_EN
  output logic [15:0]       frame_count,
  output logic [7:0]        err_count,
`endif
  output logic              frame_err
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam int unsigned XE = XW + 1;
  localparam int unsigned YE = YW + 1;

  typedef enum logic {WAIT_SOP, IN_FRAME} state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    border;

  logic          accept;
  logic          drop;
  logic          emit;
  logic          is_last;
  logic          frame_end;
  logic          masked;
  logic          err;
  logic [1:0]    flag_b;
  logic [1:0]    cur_b;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;

  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out;

  // Border width selected by freq_flag; only latched on SOP
  always_comb begin
    flag_b = 2'd0;
    case (freq_flag)
      3'd1:    flag_b = 2'd1;
      3'd2:    flag_b = 2'd2;
      default: flag_b = 2'd0;
    endcase
  end

  // Coordinates of the beat being accepted; an SOP always restarts at (0,0)
  always_comb begin
    cur_x = x;
    cur_y = y;
    cur_b = border;
    if (startofpacket_in) begin
      cur_x = '0;
      cur_y = '0;
      cur_b = flag_b;
    end
  end

  assign is_last   = (cur_x == XW'(IMG_W - 1)) && (cur_y == YW'(IMG_H - 1));
  assign drop      = (state == WAIT_SOP) && !startofpacket_in;
  assign emit      = accept && !drop;
  assign frame_end = endofpacket_in || is_last;

  always_comb begin
    masked = 1'b0;
    if (({1'b0, cur_x} < XE'(cur_b)) ||
        ({1'b0, cur_x} >= XE'(IMG_W) - XE'(cur_b)) ||
        ({1'b0, cur_y} < YE'(cur_b)) ||
        ({1'b0, cur_y} >= YE'(IMG_H) - YE'(cur_b)))
      masked = 1'b1;
  end

  // Any framing anomaly on an accepted beat raises a single error pulse
  always_comb begin
    err = 1'b0;
    if (accept) begin
      if (drop)                                      err = 1'b1;
      if ((state == IN_FRAME) && startofpacket_in)   err = 1'b1;
      if (startofpacket_in && endofpacket_in)        err = 1'b1;
      if (is_last && !endofpacket_in)                err = 1'b1;
      if (endofpacket_in && !is_last)                err = 1'b1;
    end
  end

  // Raster advance; the last pixel always ends the frame so y never passes IMG_H-1
  always_comb begin
    nxt_x = cur_x + XW'(1);
    nxt_y = cur_y;
    if (cur_x == XW'(IMG_W - 1)) begin
      nxt_x = '0;
      nxt_y = cur_y + YW'(1);
    end
    if (frame_end) begin
      nxt_x = '0;
      nxt_y = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= WAIT_SOP;
      x                 <= '0;
      y                 <= '0;
      border            <= 2'd0;
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= '0;
      frame_err         <= 1'b0;
    end else begin
      frame_err <= err;
      if (emit) begin
        valid_out         <= 1'b1;
        startofpacket_out <= startofpacket_in;
        endofpacket_out   <= frame_end;
        data_out          <= masked ? BORDER_COLOR : data_in;
        x                 <= nxt_x;
        y                 <= nxt_y;
        border            <= cur_b;
        state             <= frame_end ? WAIT_SOP : IN_FRAME;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef BORDER_STATS_EN
  // Complete frames wrap naturally; error count saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      if (emit && is_last)
        frame_count <= frame_count + 16'd1;
      if (err && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blur_border_masker.sv
// Directed self-checking bench for blur_border_masker on a reduced 8x6 frame.
module tb_blur_border_masker;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  freq_flag;
  logic        valid_in;
  logic        ready_out;
  logic        startofpacket_in;
  logic        endofpacket_in;
  logic [11:0] data_in;
  logic        valid_out;
  logic        ready_in;
  logic        startofpacket_out;
  logic        endofpacket_out;
  logic [11:0] data_out;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int um;
  int sent, got, cyc;
  bit stall_prev, in_acc;
  logic [11:0] hold_d;

  blur_border_masker #(.IMG_W(W), .IMG_H(H), .DATA_W(12), .BORDER_COLOR(12'h000)) dut (
    .clk(clk), .reset(reset), .freq_flag(freq_flag),
    .valid_in(valid_in), .ready_out(ready_out),
    .startofpacket_in(startofpacket_in), .endofpacket_in(endofpacket_in), .data_in(data_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .startofpacket_out(startofpacket_out), .endofpacket_out(endofpacket_out),
    .data_out(data_out), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bdec(input logic [2:0] f);
    return (f == 3'd1) ? 1 : (f == 3'd2) ? 2 : 0;
  endfunction

  function automatic logic [11:0] exp_pix(input int px, input int py, input int b, input logic [11:0] d);
    if (px < b || px >= W - b || py < b || py >= H - b) return 12'h000;
    return d;
  endfunction

  // Full frame with ready_in=1; freq_flag switches to ff_mid after the 6th pixel
  task automatic send_frame(input logic [2:0] ff, input logic [2:0] ff_mid, input bit last_eop,
                            input logic [11:0] base, output int unmasked);
    int b;
    b = bdec(ff);
    unmasked = 0;
    freq_flag = ff;
    for (int i = 0; i < N; i++) begin
      logic [11:0] d;
      d = base + 12'(i);
      valid_in = 1'b1;
      startofpacket_in = (i == 0);
      endofpacket_in = (i == N - 1) ? last_eop : 1'b0;
      data_in = d;
      if (i == 5) freq_flag = ff_mid;
      @(posedge clk); #1;
      chk("valid", valid_out, 1);
      chk("data", data_out, exp_pix(i % W, i / W, b, d));
      chk("sop", startofpacket_out, (i == 0));
      chk("eop", endofpacket_out, (i == N - 1));
      chk("err", frame_err, ((i == N - 1) && !last_eop));
      if (data_out == d) unmasked++;
    end
    valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", valid_out, 0);
    chk("idle_err", frame_err, 0);
  endtask

  task automatic beat(input bit s, input bit e, input logic [11:0] d);
    valid_in = 1'b1; startofpacket_in = s; endofpacket_in = e; data_in = d;
    @(posedge clk); #1;
    valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; freq_flag = 3'd0; valid_in = 1'b0; startofpacket_in = 1'b0;
    endofpacket_in = 1'b0; data_in = 12'h000; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_sop", startofpacket_out, 0);
    chk("rst_eop", endofpacket_out, 0);
    chk("rst_data", data_out, 12'h000);
    chk("rst_err", frame_err, 0);
    chk("rst_ready", ready_out, 1);
    reset = 1'b0;

    // 5x5 border: 4x2 interior of an 8x6 frame survives
    send_frame(3'd2, 3'd2, 1'b1, 12'h101, um);
    chk("unmasked_b2", um, 8);
    // No mask: every pixel passes
    send_frame(3'd0, 3'd0, 1'b1, 12'h001, um);
    chk("unmasked_b0", um, 48);
    // freq_flag 2->1 mid frame keeps 2 px border, next frame uses 1 px
    send_frame(3'd2, 3'd1, 1'b1, 12'h201, um);
    chk("unmasked_mid", um, 8);
    send_frame(3'd1, 3'd1, 1'b1, 12'h301, um);
    chk("unmasked_b1", um, 24);
    // Missing EOP on last pixel is repaired and flagged
    send_frame(3'd0, 3'd0, 1'b0, 12'h501, um);
    chk("unmasked_noeop", um, 48);

    // Five beats outside a packet are dropped
    for (int k = 0; k < 5; k++) begin
      beat(1'b0, 1'b0, 12'(k + 1));
      chk("drop_valid", valid_out, 0);
      chk("drop_err", frame_err, 1);
    end
    send_frame(3'd1, 3'd1, 1'b1, 12'h601, um);
    chk("after_drop", um, 24);

    // Early EOP then stray beat
    freq_flag = 3'd0;
    beat(1'b1, 1'b0, 12'hA01);
    chk("ee_sop", startofpacket_out, 1);
    chk("ee_err0", frame_err, 0);
    beat(1'b0, 1'b0, 12'hA02);
    beat(1'b0, 1'b1, 12'hA03);
    chk("ee_eop", endofpacket_out, 1);
    chk("ee_data", data_out, 12'hA03);
    chk("ee_err", frame_err, 1);
    beat(1'b0, 1'b0, 12'hA04);
    chk("ee_drop", valid_out, 0);
    chk("ee_drop_err", frame_err, 1);

    // SOP inside a frame restarts and relatches the border
    beat(1'b1, 1'b0, 12'hB01);
    beat(1'b0, 1'b0, 12'hB02);
    chk("sif_pass", data_out, 12'hB02);
    freq_flag = 3'd2;
    beat(1'b1, 1'b0, 12'hB03);
    chk("sif_sop", startofpacket_out, 1);
    chk("sif_err", frame_err, 1);
    chk("sif_mask00", data_out, 12'h000);
    beat(1'b0, 1'b0, 12'hB04);
    chk("sif_mask10", data_out, 12'h000);
    chk("sif_err0", frame_err, 0);
    chk("sif_nosop", startofpacket_out, 0);

    // SOP and EOP on the same beat
    beat(1'b1, 1'b1, 12'hC01);
    chk("se_sop", startofpacket_out, 1);
    chk("se_eop", endofpacket_out, 1);
    chk("se_err", frame_err, 1);

    // Reset mid-frame discards output and returns to WAIT_SOP
    freq_flag = 3'd0;
    beat(1'b1, 1'b0, 12'hD01);
    beat(1'b0, 1'b0, 12'hD02);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_valid", valid_out, 0);
    reset = 1'b0;
    beat(1'b0, 1'b0, 12'hD03);
    chk("mr_drop", valid_out, 0);
    chk("mr_err", frame_err, 1);

    // Backpressure: ready_in high one cycle in three
    freq_flag = 3'd0;
    sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; hold_d = 12'h000;
    valid_in = 1'b1; startofpacket_in = 1'b1; endofpacket_in = 1'b0; data_in = 12'h400;
    while (got < N && cyc < 1000) begin
      ready_in = (cyc % 3 == 0);
      #1;
      if (stall_prev) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_data", data_out, hold_d);
      end
      if (valid_out && ready_in) begin
        chk("st_data", data_out, 12'h400 + 12'(got));
        chk("st_sop", startofpacket_out, (got == 0));
        chk("st_eop", endofpacket_out, (got == N - 1));
        got++;
      end
      stall_prev = valid_out && !ready_in;
      hold_d = data_out;
      in_acc = valid_in && ready_out;
      @(posedge clk); #1;
      if (in_acc) begin
        sent++;
        if (sent < N) begin
          startofpacket_in = 1'b0;
          endofpacket_in = (sent == N - 1);
          data_in = 12'h400 + 12'(sent);
        end else begin
          valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
        end
      end
      cyc++;
    end
    chk("st_count", got, N);
    ready_in = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
